parking_lot_occupancy: RTL and testbench

- Parametrised single-lane car-park occupancy tracker.
- Takes two photo-sensor levels (a = outer beam, b = inner beam), synchronises them, and decodes direction with a 7-state sequence FSM.
- Maintains a capacity-limited occupancy count in binary and in parallel 2-digit BCD, so the seven-segment mux needs no divider.
- Flags full/empty, pulses on rejected entries, and latches a sticky underflow error. Sits between the debounced button/sensor inputs and the display mux.

---
 rtl/parking_lot_occupancy.sv | 192 +++++++++++++++++++
 tb/tb_parking_lot_occupancy.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_occupancy.sv
// parking_lot_occupancy
//   Single-lane car-park occupancy tracker. Two beam sensors (a = outer,
//   b = inner) are synchronised and decoded by a direction sequence FSM.
//   A capacity-limited occupancy count is held in binary and, in parallel,
//   as two BCD digits so the display mux needs no divider.
//
//   Parameters
//     CAPACITY  maximum occupancy, 1..99 (two BCD digits)
//     CNT_W     binary count width, 2**CNT_W > CAPACITY
//
//   Ports
//     clk        system clock, all state on the rising edge
//     reset      asynchronous, active-high, clears all state
//     a, b       outer / inner sensor levels, debounced but asynchronous
//     enter      one-cycle pulse: complete entry sequence decoded
//     exit       one-cycle pulse: complete exit sequence decoded
//     count      occupancy, binary
//     count_bcd  occupancy, [7:4] tens, [3:0] ones
//     full       count == CAPACITY
//     empty      count == 0
//     reject     one-cycle pulse: entry decoded while full
//     underflow  sticky: exit decoded while empty, cleared only by reset
//
//   Interface timing: there is no backpressure. enter/exit/reject are
//   single-cycle strobes with no ready; a consumer must sample them on the
//   cycle they are high. count/count_bcd/full/empty are level outputs that
//   change only on the edge after an enter/exit strobe.
module parking_lot_occupancy #(
  parameter int CAPACITY = 99,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             enter,
  output logic             exit,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       count_bcd,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ENT1 = 3'd1,
    ENT2 = 3'd2,
    ENT3 = 3'd3,
    EXT1 = 3'd4,
    EXT2 = 3'd5,
    EXT3 = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       enter_nxt;
  logic       exit_nxt;
  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic [1:0] ab;

  // ---------------------------------------------------------------
  // Two-flop synchronisers; ab is the pair the FSM decodes.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

  assign ab = {a_sync[1], b_sync[1]};

  // ---------------------------------------------------------------
  // Direction FSM. Entry walks 10 -> 11 -> 01 -> 00, exit is the
  // mirror (01 -> 11 -> 10 -> 00). A step back along the path is
  // allowed (car hesitating); any other jump abandons the sequence.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      state <= state_nxt;
      enter <= enter_nxt;
      exit  <= exit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ab == 2'b10)      state_nxt = ENT1;
        else if (ab == 2'b01) state_nxt = EXT1;
      end
      ENT1: begin
        if (ab == 2'b11)                        state_nxt = ENT2;
        else if (ab == 2'b00 || ab == 2'b01)    state_nxt = IDLE;
      end
      ENT2: begin
        if (ab == 2'b01)      state_nxt = ENT3;
        else if (ab == 2'b10) state_nxt = ENT1;
        else if (ab == 2'b00) state_nxt = IDLE;
      end
      ENT3: begin
        if (ab == 2'b00) begin
          state_nxt = IDLE;
          enter_nxt = 1'b1;
        end else if (ab == 2'b11) begin
          state_nxt = ENT2;
        end else if (ab == 2'b10) begin
          state_nxt = IDLE;
        end
      end
      EXT1: begin
        if (ab == 2'b11)                        state_nxt = EXT2;
        else if (ab == 2'b00 || ab == 2'b10)    state_nxt = IDLE;
      end
      EXT2: begin
        if (ab == 2'b10)      state_nxt = EXT3;
        else if (ab == 2'b01) state_nxt = EXT1;
        else if (ab == 2'b00) state_nxt = IDLE;
      end
      EXT3: begin
        if (ab == 2'b00) begin
          state_nxt = IDLE;
          exit_nxt  = 1'b1;
        end else if (ab == 2'b11) begin
          state_nxt = EXT2;
        end else if (ab == 2'b01) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Occupancy counter, binary and BCD updated side by side so the two
  // always agree without a binary-to-BCD conversion.
  // ---------------------------------------------------------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      count_bcd <= 8'h00;
      reject    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (enter) begin
        if (count < CAP_C) begin
          count     <= count + CNT_W'(1);
          count_bcd <= bcd_inc(count_bcd);
        end else begin
          reject <= 1'b1;
        end
      end else if (exit) begin
        if (count != '0) begin
          count     <= count - CNT_W'(1);
          count_bcd <= bcd_dec(count_bcd);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  assign full  = (count == CAP_C);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Bench for parking_lot_occupancy. Two instances run side by side on the
// same sensor stimulus: a small one (CAPACITY=3, CNT_W=2) for saturation
// and reject behaviour, and a default one (CAPACITY=99) for BCD carries.
module tb_parking_lot_occupancy;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       enter_s, exit_s, full_s, empty_s, reject_s, uf_s;
  logic [1:0] count_s;
  logic [7:0] bcd_s;
  logic       enter_b, exit_b, full_b, empty_b, reject_b, uf_b;
  logic [6:0] count_b;
  logic [7:0] bcd_b;

  parking_lot_occupancy #(.CAPACITY(3), .CNT_W(2)) dut_s (
    .clk(clk), .reset(rst), .a(a), .b(b),
    .enter(enter_s), .exit(exit_s), .count(count_s), .count_bcd(bcd_s),
    .full(full_s), .empty(empty_s), .reject(reject_s), .underflow(uf_s)
  );

  parking_lot_occupancy dut_b (
    .clk(clk), .reset(rst), .a(a), .b(b),
    .enter(enter_b), .exit(exit_b), .count(count_b), .count_bcd(bcd_b),
    .full(full_b), .empty(empty_b), .reject(reject_b), .underflow(uf_b)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The direction decode is a walk along the ordered path
  // 00 -> p1 -> p2 -> p3 -> 00. Moving one step either way is allowed,
  // arriving at 00 from p3 completes the gesture, any other jump (or
  // falling back to 00 from p1) drops the gesture.
  logic [1:0] ms1 = 2'b00, ms2 = 2'b00;
  int   mode = 0;   // 0 none, 1 entering, 2 exiting
  int   pos  = 0;
  logic m_enter = 1'b0, m_exit = 1'b0;
  int   m_cnt[2] = '{0, 0};
  logic m_rej[2] = '{1'b0, 1'b0};
  logic m_uf[2]  = '{1'b0, 1'b0};
  int   caps[2]  = '{3, 99};

  function automatic int path_pos(input logic [1:0] c, input int dir);
    logic [1:0] e;
    e = (dir == 1) ? c : {c[0], c[1]};
    case (e)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int q;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ms1 = 2'b00; ms2 = 2'b00; mode = 0; pos = 0;
        m_enter = 1'b0; m_exit = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 0; m_rej[k] = 1'b0; m_uf[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_rej[k] = 1'b0;
          if (m_enter) begin
            if (m_cnt[k] < caps[k]) m_cnt[k]++;
            else                    m_rej[k] = 1'b1;
          end
          if (m_exit) begin
            if (m_cnt[k] > 0) m_cnt[k]--;
            else              m_uf[k] = 1'b1;
          end
        end
        m_enter = 1'b0;
        m_exit  = 1'b0;
        if (mode == 0) begin
          if (ms2 == 2'b10)      begin mode = 1; pos = 1; end
          else if (ms2 == 2'b01) begin mode = 2; pos = 1; end
        end else begin
          q = path_pos(ms2, mode);
          if (q == pos) begin
            // holding position
          end else if (pos == 3 && q == 0) begin
            if (mode == 1) m_enter = 1'b1;
            else           m_exit  = 1'b1;
            mode = 0;
          end else if (q == pos + 1 || q == pos - 1) begin
            if (q == 0) mode = 0;
            else        pos  = q;
          end else begin
            mode = 0;
          end
        end
        ms2 = ms1;
        ms1 = {a, b};
      end
    end
  end

  function automatic logic [20:0] exp_vec(input int k);
    logic [6:0] c;
    logic [3:0] t, o;
    c = 7'(m_cnt[k]);
    t = 4'(m_cnt[k] / 10);
    o = 4'(m_cnt[k] % 10);
    return {m_enter, m_exit, c, t, o, (m_cnt[k] == caps[k]), (m_cnt[k] == 0),
            m_rej[k], m_uf[k]};
  endfunction

  // ---------------- per-cycle scoreboard + pulse counters ----------------
  int n_ent_s = 0, n_ext_s = 0, n_rej_s = 0;
  int n_ent_b = 0, n_ext_b = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cycle_small",
              {enter_s, exit_s, 5'b0, count_s, bcd_s, full_s, empty_s, reject_s, uf_s},
              exp_vec(0));
        check("cycle_big",
              {enter_b, exit_b, count_b, bcd_b, full_b, empty_b, reject_b, uf_b},
              exp_vec(1));
      end
      n_ent_s += int'(enter_s);
      n_ext_s += int'(exit_s);
      n_rej_s += int'(reject_s);
      n_ent_b += int'(enter_b);
      n_ext_b += int'(exit_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [1:0] ab, input int n);
    a = ab[1];
    b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  // Plays len codes from seq (first code in the top two bits); each held
  // hn cycles (hn==0: random 1..5), the last held 8 cycles so the
  // resulting event has fully landed in the count.
  task automatic gesture(input logic [15:0] seq, input int len, input int hn);
    for (int j = 0; j < len; j++) begin
      if (j == len - 1)  hold(seq[15-2*j -: 2], 8);
      else if (hn == 0)  hold(seq[15-2*j -: 2], int'($urandom_range(1, 5)));
      else               hold(seq[15-2*j -: 2], hn);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [15:0] SEQ_ENT  = 16'b0010_1101_0000_0000; // 00 10 11 01 00
  localparam logic [15:0] SEQ_EXT  = 16'b0001_1110_0000_0000; // 00 01 11 10 00
  localparam logic [15:0] SEQ_AB1  = 16'b0010_0000_0000_0000; // 00 10 00
  localparam logic [15:0] SEQ_AB2  = 16'b0010_1110_0000_0000; // 00 10 11 10 00
  localparam logic [15:0] SEQ_BENT = 16'b0010_1110_1101_0000; // 00 10 11 10 11 01 00
  localparam logic [15:0] SEQ_BEXT = 16'b0001_1101_1110_0000; // 00 01 11 01 11 10 00

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] seq;
    int          len;
    logic [1:0]  exp_cnt_s;
    logic [7:0]  exp_bcd_b;
    logic        exp_full_s;
    logic [2:0]  exp_deltas_s;  // {enter, exit, reject} pulses on small DUT
  } vec_t;

  vec_t tbl[9];

  // ---------------- main sequence ----------------
  initial begin
    int   d_ent, d_ext, d_rej, d_ent_b, d_ext_b;
    logic [6:0] lat_cnt[6];
    logic       lat_ent[6];
    logic [15:0] rs;
    int   g, rl;

    tbl[0] = '{SEQ_ENT,  5, 2'd1, 8'h01, 1'b0, 3'b100};
    tbl[1] = '{SEQ_AB1,  3, 2'd1, 8'h01, 1'b0, 3'b000};
    tbl[2] = '{SEQ_AB2,  5, 2'd1, 8'h01, 1'b0, 3'b000};
    tbl[3] = '{SEQ_ENT,  5, 2'd2, 8'h02, 1'b0, 3'b100};
    tbl[4] = '{SEQ_ENT,  5, 2'd3, 8'h03, 1'b1, 3'b100};
    tbl[5] = '{SEQ_ENT,  5, 2'd3, 8'h04, 1'b1, 3'b101};
    tbl[6] = '{SEQ_EXT,  5, 2'd2, 8'h03, 1'b0, 3'b010};
    tbl[7] = '{SEQ_BENT, 7, 2'd3, 8'h04, 1'b1, 3'b100};
    tbl[8] = '{SEQ_BEXT, 7, 2'd2, 8'h03, 1'b0, 3'b010};

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count_s", {30'd0, count_s}, 32'd0);
    check("rst_count_b", {25'd0, count_b}, 32'd0);
    check("rst_bcd_b", {24'd0, bcd_b}, 32'h00);
    check("rst_flags_s", {28'd0, full_s, empty_s, reject_s, uf_s}, 32'b0100);
    check("rst_flags_b", {28'd0, full_b, empty_b, reject_b, uf_b}, 32'b0100);
    check("rst_pulses", {28'd0, enter_s, exit_s, enter_b, exit_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Table-driven gestures
    for (int i = 0; i < 9; i++) begin
      d_ent = n_ent_s; d_ext = n_ext_s; d_rej = n_rej_s;
      gesture(tbl[i].seq, tbl[i].len, 4);
      check($sformatf("tbl%0d_count_s", i), {30'd0, count_s}, {30'd0, tbl[i].exp_cnt_s});
      check($sformatf("tbl%0d_bcd_b", i), {24'd0, bcd_b}, {24'd0, tbl[i].exp_bcd_b});
      check($sformatf("tbl%0d_full_s", i), {31'd0, full_s}, {31'd0, tbl[i].exp_full_s});
      check($sformatf("tbl%0d_pulses_s", i),
            {29'd0, 1'(n_ent_s - d_ent), 1'(n_ext_s - d_ext), 1'(n_rej_s - d_rej)},
            {29'd0, tbl[i].exp_deltas_s});
    end

    // Latency: sensor return to 00 -> enter after 3 edges, count after 4
    do_reset();
    d_ext_b = n_ext_b;
    hold(2'b10, 4);
    hold(2'b11, 4);
    hold(2'b01, 4);
    a = 1'b0; b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      lat_cnt[k] = count_b;
      lat_ent[k] = enter_b;
    end
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("lat_enter_e2", {31'd0, lat_ent[2]}, 32'd0);
    check("lat_enter_e3", {31'd0, lat_ent[3]}, 32'd1);
    check("lat_count_e3", {25'd0, lat_cnt[3]}, 32'd0);
    check("lat_enter_e4", {31'd0, lat_ent[4]}, 32'd0);
    check("lat_count_e4", {25'd0, lat_cnt[4]}, 32'd1);
    check("lat_no_exit", n_ext_b - d_ext_b, 32'd0);

    // Underflow: exit while empty, sticky through later entries
    do_reset();
    d_ext = n_ext_s;
    gesture(SEQ_EXT, 5, 4);
    check("uf_exit_pulse", n_ext_s - d_ext, 32'd1);
    check("uf_count_s", {30'd0, count_s}, 32'd0);
    check("uf_flag_s", {31'd0, uf_s}, 32'd1);
    check("uf_flag_b", {31'd0, uf_b}, 32'd1);
    gesture(SEQ_ENT, 5, 4);
    check("uf_sticky_cnt", {25'd0, count_b}, 32'd1);
    check("uf_sticky_b", {31'd0, uf_b}, 32'd1);
    do_reset();
    check("uf_cleared_b", {31'd0, uf_b}, 32'd0);

    // BCD carry 09 -> 10 and borrow 10 -> 09 on the default instance
    for (int i = 0; i < 9; i++) gesture(SEQ_ENT, 5, 4);
    check("bcd_09", {24'd0, bcd_b}, 32'h09);
    check("bcd_09_cnt", {25'd0, count_b}, 32'd9);
    check("bcd_small_sat", {29'd0, count_s, full_s}, 32'b111);
    gesture(SEQ_ENT, 5, 4);
    check("bcd_10", {24'd0, bcd_b}, 32'h10);
    check("bcd_10_cnt", {25'd0, count_b}, 32'd10);
    gesture(SEQ_EXT, 5, 4);
    check("bcd_back_09", {24'd0, bcd_b}, 32'h09);

    // Reset in the middle of an entry (FSM sitting in its second step)
    hold(2'b10, 4);
    hold(2'b11, 4);
    rst = 1'b1;
    #1;
    check("midrst_count_b", {25'd0, count_b}, 32'd0);
    check("midrst_bcd_b", {24'd0, bcd_b}, 32'h00);
    check("midrst_empty_b", {31'd0, empty_b}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    d_ent_b = n_ent_b; d_ext_b = n_ext_b;
    hold(2'b11, 4);
    hold(2'b01, 4);
    hold(2'b00, 8);
    check("midrst_no_pulse", {30'd0, 1'(n_ent_b - d_ent_b), 1'(n_ext_b - d_ext_b)}, 32'd0);
    check("midrst_count_after", {25'd0, count_b}, 32'd0);

    // Randomised gestures against the reference model
    for (int i = 0; i < 80; i++) begin
      g = int'($urandom_range(0, 4));
      case (g)
        0, 4: gesture(SEQ_ENT, 5, 0);
        1:    gesture(SEQ_EXT, 5, 0);
        2:    gesture(SEQ_BENT, 7, 0);
        default: begin
          rs = 16'($urandom);
          rl = int'($urandom_range(2, 8));
          gesture(rs, rl, 0);
        end
      endcase
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
